// File: rtl/coin_pkg.sv
// Types and helpers shared between the coin acceptor and the change box.
// A coin's encoding equals its value in nickels, so value decoding is a zero-extend.
package coin_pkg;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        NICKEL  = 3'd1,
        DIME    = 3'd2,
        QUARTER = 3'd5
    } coin_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REQ     = 2'd2
    } acc_state_e;

    localparam int MAX_NICKELS = 15;

    // Bit positions of the tubes in the one-hot selects.
    localparam int TUBE_N = 0;
    localparam int TUBE_D = 1;
    localparam int TUBE_Q = 2;

    function automatic logic [2:0] tube_sel(input logic [2:0] c);
        case (c)
            NICKEL:  tube_sel = 3'b001;
            DIME:    tube_sel = 3'b010;
            QUARTER: tube_sel = 3'b100;
            default: tube_sel = 3'b000;
        endcase
    endfunction

    function automatic logic is_coin(input logic [2:0] c);
        is_coin = |tube_sel(c);
    endfunction

    function automatic logic [4:0] coin_nickels(input logic [2:0] c);
        coin_nickels = is_coin(c) ? {2'b00, c} : 5'd0;
    endfunction

endpackage

// File: rtl/coin_tube.sv
// Two-bit coin tube counter. Simultaneous increment and decrement cancel out;
// the counter refuses to wrap in either direction.
module coin_tube #(
    parameter logic [1:0] INIT = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] count_o,
    output logic       empty_o,
    output logic       full_o
);

    logic [1:0] count_q;
    logic [1:0] count_d;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd3);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({inc_i, dec_i})
            2'b10:   if (!full_o)  count_d = count_q + 2'd1;
            2'b01:   if (!empty_o) count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= INIT;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Payment front end: collects coins against a latched cost, keeps the Q/D/N tube
// inventory current with dispense decrements, and offers {cost, paid} to the change box.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int         Q_INIT  = 2,
    parameter int         D_INIT  = 2,
    parameter int         N_INIT  = 2,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cost_in,
    input  logic       coin_valid,
    input  logic [2:0] coin_val,
    input  logic       cancel,
    input  logic       disp_valid,
    input  logic [2:0] disp_coin,
    input  logic       txn_ready,
    output logic       txn_valid,
    output logic [3:0] cost_o,
    output logic [3:0] paid_o,
    output logic [1:0] quarters,
    output logic [1:0] dimes,
    output logic [1:0] nickels,
    output logic       coin_accept,
    output logic       coin_reject,
    output logic       disp_err,
    output logic       busy
);

    acc_state_e state_q;
    logic [3:0] cost_q;
    logic [3:0] paid_q;
    logic [7:0] timer_q;
    logic       coin_accept_q;
    logic       coin_reject_q;
    logic       disp_err_q;

    logic [2:0] coin_sel;
    logic [2:0] disp_sel;
    logic [2:0] tube_full;
    logic [2:0] tube_empty;
    logic [2:0] tube_inc;
    logic [2:0] tube_dec;
    logic [1:0] tube_cnt [3];
    logic [4:0] paid_sum;
    logic [3:0] paid_d;
    logic       accept;
    logic       disp_ok;
    logic       timeout_hit;

    assign coin_sel = tube_sel(coin_val);
    assign disp_sel = tube_sel(disp_coin);
    assign paid_sum = {1'b0, paid_q} + coin_nickels(coin_val);
    assign paid_d   = paid_sum[3:0];

    assign accept = coin_valid && (state_q == COLLECT) && !cancel && (|coin_sel)
                 && (paid_sum <= 5'(MAX_NICKELS)) && !(|(coin_sel & tube_full));

    assign disp_ok = disp_valid && (|disp_sel) && !(|(disp_sel & tube_empty));

    // An accepted coin in the last allowed cycle rescues the transaction.
    assign timeout_hit = (TIMEOUT != 8'd0) && !accept && ((timer_q + 8'd1) == TIMEOUT);

    assign tube_inc = accept  ? coin_sel : 3'b000;
    assign tube_dec = disp_ok ? disp_sel : 3'b000;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tube
            localparam logic [1:0] INIT_G = (gi == TUBE_Q) ? 2'(Q_INIT) :
                                            (gi == TUBE_D) ? 2'(D_INIT) : 2'(N_INIT);
            coin_tube #(.INIT(INIT_G)) u_tube (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc_i   (tube_inc[gi]),
                .dec_i   (tube_dec[gi]),
                .count_o (tube_cnt[gi]),
                .empty_o (tube_empty[gi]),
                .full_o  (tube_full[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cost_q        <= 4'd0;
            paid_q        <= 4'd0;
            timer_q       <= 8'd0;
            coin_accept_q <= 1'b0;
            coin_reject_q <= 1'b0;
            disp_err_q    <= 1'b0;
        end else begin
            coin_accept_q <= accept;
            coin_reject_q <= coin_valid && !accept;
            disp_err_q    <= disp_valid && !disp_ok;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cost_q  <= cost_in;
                        timer_q <= 8'd0;
                        state_q <= (cost_in == 4'd0) ? REQ : COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        paid_q  <= paid_d;
                        timer_q <= 8'd0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                    // Abort wins: a zero cost tells the change box to refund everything.
                    if (cancel || timeout_hit) begin
                        cost_q  <= 4'd0;
                        state_q <= REQ;
                    end else if (paid_q >= cost_q) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (txn_ready) begin
                        paid_q  <= 4'd0;
                        cost_q  <= 4'd0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign txn_valid   = (state_q == REQ);
    assign busy        = (state_q != IDLE);
    assign cost_o      = cost_q;
    assign paid_o      = paid_q;
    assign quarters    = tube_cnt[TUBE_Q];
    assign dimes       = tube_cnt[TUBE_D];
    assign nickels     = tube_cnt[TUBE_N];
    assign coin_accept = coin_accept_q;
    assign coin_reject = coin_reject_q;
    assign disp_err    = disp_err_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: purchase, boundaries, hold, cancel,
// dispense, timeout and asynchronous reset scenarios with hand-computed results.
module tb_coin_acceptor;

    localparam logic [2:0] CN = 3'b001;
    localparam logic [2:0] CD = 3'b010;
    localparam logic [2:0] CQ = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] cost_in;
    logic       coin_valid;
    logic [2:0] coin_val;
    logic       cancel;
    logic       disp_valid;
    logic [2:0] disp_coin;
    logic       txn_ready;
    logic       txn_valid;
    logic [3:0] cost_o;
    logic [3:0] paid_o;
    logic [1:0] quarters;
    logic [1:0] dimes;
    logic [1:0] nickels;
    logic       coin_accept;
    logic       coin_reject;
    logic       disp_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    coin_acceptor #(.Q_INIT(2), .D_INIT(2), .N_INIT(2), .TIMEOUT(8'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cost_in     (cost_in),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .cancel      (cancel),
        .disp_valid  (disp_valid),
        .disp_coin   (disp_coin),
        .txn_ready   (txn_ready),
        .txn_valid   (txn_valid),
        .cost_o      (cost_o),
        .paid_o      (paid_o),
        .quarters    (quarters),
        .dimes       (dimes),
        .nickels     (nickels),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject),
        .disp_err    (disp_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [2:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        tick();
        coin_valid = 1'b0;
        coin_val   = 3'b000;
    endtask

    task automatic do_disp(input logic [2:0] v);
        disp_valid = 1'b1;
        disp_coin  = v;
        tick();
        disp_valid = 1'b0;
        disp_coin  = 3'b000;
    endtask

    task automatic begin_txn(input logic [3:0] c);
        cost_in = c;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic finish_txn();
        txn_ready = 1'b1;
        tick();
        txn_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if ({txn_valid, busy} !== 2'b00) begin n_err++; $display("FAIL reset_valid_busy: got %b want 00", {txn_valid, busy}); end
        n_cmp++; if ({cost_o, paid_o} !== 8'h00) begin n_err++; $display("FAIL reset_cost_paid: got %h want 00", {cost_o, paid_o}); end
        n_cmp++; if ({coin_accept, coin_reject, disp_err} !== 3'b000) begin n_err++; $display("FAIL reset_pulses: got %b want 000", {coin_accept, coin_reject, disp_err}); end
        n_cmp++; if ({quarters, dimes, nickels} !== 6'b10_10_10) begin n_err++; $display("FAIL reset_tubes: got %b want 101010", {quarters, dimes, nickels}); end
        rst_n = 1'b1;
        tick();
        $display("reset: tubes q=%0d d=%0d n=%0d busy=%0d", quarters, dimes, nickels, busy);
    endtask

    // Tubes Q2 D2 N2 -> Q3 D3 N2
    task automatic test_purchase();
        begin_txn(4'd7);
        n_cmp++; if ({busy, txn_valid} !== 2'b10) begin n_err++; $display("FAIL purchase_collect: got %b want 10", {busy, txn_valid}); end
        put_coin(CQ);
        n_cmp++; if ({coin_accept, coin_reject, paid_o, quarters} !== {2'b10, 4'd5, 2'd3}) begin n_err++; $display("FAIL purchase_q: got acc=%b rej=%b paid=%0d q=%0d", coin_accept, coin_reject, paid_o, quarters); end
        put_coin(CD);
        n_cmp++; if ({coin_accept, paid_o, dimes, txn_valid} !== {1'b1, 4'd7, 2'd3, 1'b0}) begin n_err++; $display("FAIL purchase_d: got acc=%b paid=%0d d=%0d valid=%b", coin_accept, paid_o, dimes, txn_valid); end
        tick();
        n_cmp++; if ({txn_valid, cost_o, paid_o, coin_accept} !== {1'b1, 4'd7, 4'd7, 1'b0}) begin n_err++; $display("FAIL purchase_txn: got valid=%b cost=%0d paid=%0d acc=%b want 1 7 7 0", txn_valid, cost_o, paid_o, coin_accept); end
        finish_txn();
        n_cmp++; if ({txn_valid, busy, cost_o, paid_o} !== 10'd0) begin n_err++; $display("FAIL purchase_done: got valid=%b busy=%b cost=%0d paid=%0d", txn_valid, busy, cost_o, paid_o); end
        $display("purchase: cost=7 paid Q+D, tubes q=%0d d=%0d n=%0d", quarters, dimes, nickels);
    endtask

    // Tubes Q3 D3 N2 -> drained to Q0 D1 N2 -> ends in REQ with Q2 D2 N3 then D3
    task automatic test_boundary();
        repeat (3) do_disp(CQ);
        n_cmp++; if ({quarters, disp_err} !== 3'b00_0) begin n_err++; $display("FAIL drain_q: got q=%0d err=%b want 0 0", quarters, disp_err); end
        do_disp(CQ);
        n_cmp++; if ({quarters, disp_err} !== 3'b00_1) begin n_err++; $display("FAIL disp_empty_q: got q=%0d err=%b want 0 1", quarters, disp_err); end
        repeat (2) do_disp(CD);
        n_cmp++; if (dimes !== 2'd1) begin n_err++; $display("FAIL drain_d: got %0d want 1", dimes); end
        begin_txn(4'd15);
        put_coin(CQ);
        put_coin(CN);
        n_cmp++; if ({paid_o, quarters, nickels} !== {4'd6, 2'd1, 2'd3}) begin n_err++; $display("FAIL bound_fill: got paid=%0d q=%0d n=%0d want 6 1 3", paid_o, quarters, nickels); end
        put_coin(CN);
        n_cmp++; if ({coin_accept, coin_reject, paid_o, nickels} !== {2'b01, 4'd6, 2'd3}) begin n_err++; $display("FAIL tube_full_reject: got acc=%b rej=%b paid=%0d n=%0d", coin_accept, coin_reject, paid_o, nickels); end
        put_coin(CQ);
        put_coin(CD);
        n_cmp++; if ({paid_o, quarters, dimes} !== {4'd13, 2'd2, 2'd2}) begin n_err++; $display("FAIL bound_13: got paid=%0d q=%0d d=%0d want 13 2 2", paid_o, quarters, dimes); end
        put_coin(CQ);
        n_cmp++; if ({coin_accept, coin_reject, paid_o, quarters} !== {2'b01, 4'd13, 2'd2}) begin n_err++; $display("FAIL overflow_reject: got acc=%b rej=%b paid=%0d q=%0d", coin_accept, coin_reject, paid_o, quarters); end
        put_coin(CD);
        n_cmp++; if ({coin_accept, paid_o, dimes} !== {1'b1, 4'd15, 2'd3}) begin n_err++; $display("FAIL exact_15: got acc=%b paid=%0d d=%0d want 1 15 3", coin_accept, paid_o, dimes); end
        tick();
        n_cmp++; if ({txn_valid, cost_o, paid_o} !== {1'b1, 4'd15, 4'd15}) begin n_err++; $display("FAIL bound_txn: got valid=%b cost=%0d paid=%0d want 1 15 15", txn_valid, cost_o, paid_o); end
        $display("boundary: paid=%0d cost=%0d", paid_o, cost_o);
    endtask

    // Entered in REQ from test_boundary; Q2 D3 N3
    task automatic test_txn_hold();
        coin_valid = 1'b1;
        coin_val   = CQ;
        for (int i = 0; i < 5; i++) begin
            tick();
            coin_valid = 1'b0;
            coin_val   = 3'b000;
            if (i == 0) begin
                n_cmp++; if ({coin_reject, coin_accept, quarters} !== {2'b10, 2'd2}) begin n_err++; $display("FAIL req_coin_reject: got rej=%b acc=%b q=%0d", coin_reject, coin_accept, quarters); end
            end
            n_cmp++; if ({txn_valid, cost_o, paid_o} !== {1'b1, 4'd15, 4'd15}) begin n_err++; $display("FAIL hold_%0d: got valid=%b cost=%0d paid=%0d", i, txn_valid, cost_o, paid_o); end
        end
        finish_txn();
        n_cmp++; if ({txn_valid, busy, paid_o, cost_o} !== 10'd0) begin n_err++; $display("FAIL hold_release: got valid=%b busy=%b paid=%0d cost=%0d", txn_valid, busy, paid_o, cost_o); end
        $display("txn_hold: held 5 cycles then released");
    endtask

    // Q2 D3 N3 -> D1 -> D3 after two dimes
    task automatic test_cancel();
        repeat (2) do_disp(CD);
        begin_txn(4'd15);
        put_coin(CD);
        put_coin(CD);
        n_cmp++; if ({paid_o, dimes} !== {4'd4, 2'd3}) begin n_err++; $display("FAIL cancel_paid: got paid=%0d d=%0d want 4 3", paid_o, dimes); end
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_val   = CQ;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        coin_val   = 3'b000;
        n_cmp++; if ({coin_reject, coin_accept, quarters} !== {2'b10, 2'd2}) begin n_err++; $display("FAIL cancel_coin: got rej=%b acc=%b q=%0d", coin_reject, coin_accept, quarters); end
        n_cmp++; if ({txn_valid, cost_o, paid_o} !== {1'b1, 4'd0, 4'd4}) begin n_err++; $display("FAIL cancel_txn: got valid=%b cost=%0d paid=%0d want 1 0 4", txn_valid, cost_o, paid_o); end
        finish_txn();
        $display("cancel: refund txn completed, busy=%0d", busy);
    endtask

    // Q2 D3 N3 -> N0 -> ends N1
    task automatic test_dispense();
        repeat (3) do_disp(CN);
        n_cmp++; if (nickels !== 2'd0) begin n_err++; $display("FAIL drain_n: got %0d want 0", nickels); end
        do_disp(CN);
        n_cmp++; if ({disp_err, nickels} !== 3'b1_00) begin n_err++; $display("FAIL disp_empty_n: got err=%b n=%0d want 1 0", disp_err, nickels); end
        do_disp(3'b011);
        n_cmp++; if ({disp_err, quarters, dimes, nickels} !== {1'b1, 2'd2, 2'd3, 2'd0}) begin n_err++; $display("FAIL disp_bad: got err=%b tubes=%b", disp_err, {quarters, dimes, nickels}); end
        begin_txn(4'd2);
        put_coin(CN);
        n_cmp++; if ({paid_o, nickels} !== {4'd1, 2'd1}) begin n_err++; $display("FAIL disp_accept1: got paid=%0d n=%0d want 1 1", paid_o, nickels); end
        coin_valid = 1'b1;
        coin_val   = CN;
        disp_valid = 1'b1;
        disp_coin  = CN;
        tick();
        coin_valid = 1'b0;
        coin_val   = 3'b000;
        disp_valid = 1'b0;
        disp_coin  = 3'b000;
        n_cmp++; if ({coin_accept, disp_err, nickels, paid_o} !== {2'b10, 2'd1, 4'd2}) begin n_err++; $display("FAIL acc_disp_same: got acc=%b err=%b n=%0d paid=%0d", coin_accept, disp_err, nickels, paid_o); end
        tick();
        n_cmp++; if ({txn_valid, cost_o, paid_o} !== {1'b1, 4'd2, 4'd2}) begin n_err++; $display("FAIL disp_txn: got valid=%b cost=%0d paid=%0d", txn_valid, cost_o, paid_o); end
        finish_txn();
        $display("dispense: tubes q=%0d d=%0d n=%0d", quarters, dimes, nickels);
    endtask

    task automatic test_zero_cost();
        begin_txn(4'd0);
        n_cmp++; if ({txn_valid, busy, cost_o, paid_o} !== {2'b11, 8'h00}) begin n_err++; $display("FAIL zero_cost: got valid=%b busy=%b cost=%0d paid=%0d", txn_valid, busy, cost_o, paid_o); end
        finish_txn();
        $display("zero_cost: direct to request");
    endtask

    task automatic test_timeout();
        begin_txn(4'd5);
        repeat (3) tick();
        n_cmp++; if ({txn_valid, busy} !== 2'b01) begin n_err++; $display("FAIL timeout_early: got valid=%b busy=%b want 0 1", txn_valid, busy); end
        tick();
        n_cmp++; if ({txn_valid, cost_o, paid_o} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL timeout_req: got valid=%b cost=%0d paid=%0d want 1 0 0", txn_valid, cost_o, paid_o); end
        finish_txn();
        $display("timeout: auto-cancel after 4 idle cycles");
    endtask

    // Q2 D3 N1 -> Q3 then reset restores 2/2/2
    task automatic test_async_reset();
        begin_txn(4'd9);
        put_coin(CQ);
        n_cmp++; if ({paid_o, quarters} !== {4'd5, 2'd3}) begin n_err++; $display("FAIL pre_reset: got paid=%0d q=%0d want 5 3", paid_o, quarters); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, txn_valid, cost_o, paid_o} !== 10'd0) begin n_err++; $display("FAIL async_reset_state: got busy=%b valid=%b cost=%0d paid=%0d", busy, txn_valid, cost_o, paid_o); end
        n_cmp++; if ({quarters, dimes, nickels, coin_accept} !== {6'b10_10_10, 1'b0}) begin n_err++; $display("FAIL async_reset_tubes: got tubes=%b acc=%b", {quarters, dimes, nickels}, coin_accept); end
        tick();
        rst_n = 1'b1;
        tick();
        $display("async_reset: busy=%0d tubes q=%0d d=%0d n=%0d", busy, quarters, dimes, nickels);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        cost_in    = 4'd0;
        coin_valid = 1'b0;
        coin_val   = 3'b000;
        cancel     = 1'b0;
        disp_valid = 1'b0;
        disp_coin  = 3'b000;
        txn_ready  = 1'b0;
        test_reset();
        test_purchase();
        test_boundary();
        test_txn_hold();
        test_cancel();
        test_dispense();
        test_zero_cost();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
